// File: rtl/barrel_shift_pkg.sv
// Shared types and constants for the barrel-shift sequencer: operand/amount widths,
// the queued command record and the output-stage FSM states.
package barrel_shift_pkg;

    localparam int N = 8;
    localparam int M = 3;

    typedef struct packed {
        logic [N-1:0] data;
        logic [M-1:0] num;
        logic         lr;
    } shift_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } seq_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/modified_barrel_shift.sv
// Combinational N-bit circular rotator; LR=1 rotates left, LR=0 rotates right.
module modified_barrel_shift
    import barrel_shift_pkg::*;
(
    output logic [N-1:0] Out,
    input  logic [N-1:0] In,
    input  logic [M-1:0] Num,
    input  logic         LR
);

    logic [M-1:0] shamt;

    // A left rotate by k is a right rotate by (N-k) mod N, so one shifter serves both.
    always_comb begin
        shamt = LR ? (-Num) : Num;
        Out   = N'({In, In} >> shamt);
    end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Command FIFO feeding a registered rotator output stage with valid/ready on both sides.
// Optional completed-command statistics are built when BSEQ_STATS_EN is defined.
module barrel_shift_sequencer
    import barrel_shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [N-1:0]             InData,
    input  logic [M-1:0]             InNum,
    input  logic                     InLR,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [N-1:0]             OutData,
    input  logic                     Flush,
    output logic [$clog2(DEPTH):0]   Level,
    output logic [15:0]              LeftCount,
    output logic [15:0]              RightCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    shift_cmd_t     mem_q [DEPTH];
    shift_cmd_t     cmd_in;
    shift_cmd_t     head;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic           pop_req, push, pop;
    logic [N-1:0]   rot_out;
    logic [N-1:0]   out_data_q;
    seq_state_e     state_q, state_d;

    assign cmd_in = '{data: InData, num: InNum, lr: InLR};
    assign head   = mem_q[rptr_q];

    // Readiness ignores Flush; a flushed push is simply dropped.
    always_comb begin
        pop_req = (level_q != '0) && (!OutValid || OutReady);
        InReady = (level_q != LW'(DEPTH)) || pop_req;
        push    = InValid && InReady && !Flush;
        pop     = pop_req && !Flush;
    end

    always_comb begin
        level_d = level_q;
        if (Flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (Flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wptr_q] <= cmd_in;
    end

    modified_barrel_shift u_rot (
        .Out (rot_out),
        .In  (head.data),
        .Num (head.num),
        .LR  (head.lr)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pop) state_d = ST_FULL;
            ST_FULL: begin
                if (Flush)         state_d = ST_IDLE;
                else if (pop)      state_d = ST_FULL;
                else if (OutReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        OutValid = 1'b0;
        if (state_q == ST_FULL) OutValid = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)   out_data_q <= '0;
        else if (pop) out_data_q <= rot_out;
    end

    assign OutData = out_data_q;
    assign Level   = level_q;

`ifdef BSEQ_STATS_EN
    logic        out_lr_q;
    logic [15:0] left_cnt_q, right_cnt_q;

    // Direction of the result currently held, so the handshake can be attributed.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_lr_q    <= 1'b0;
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
        end else begin
            if (pop) out_lr_q <= head.lr;
            if (OutValid && OutReady) begin
                if (out_lr_q) left_cnt_q  <= sat_inc16(left_cnt_q);
                else          right_cnt_q <= sat_inc16(right_cnt_q);
            end
        end
    end

    assign LeftCount  = left_cnt_q;
    assign RightCount = right_cnt_q;
`else
    assign LeftCount  = '0;
    assign RightCount = '0;
`endif

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Self-checking bench for barrel_shift_sequencer: queue-based reference model plus
// directed literal scenarios and a randomized traffic phase.
module tb_barrel_shift_sequencer;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        InValid = 1'b0;
    logic [7:0]  InData = '0;
    logic [2:0]  InNum = '0;
    logic        InLR = 1'b0;
    logic        OutReady = 1'b0;
    logic        Flush = 1'b0;
    wire         InReady;
    wire         OutValid;
    wire [7:0]   OutData;
    wire [$clog2(DEPTH):0] Level;
    wire [15:0]  LeftCount;
    wire [15:0]  RightCount;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    barrel_shift_sequencer #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .InValid    (InValid),
        .InReady    (InReady),
        .InData     (InData),
        .InNum      (InNum),
        .InLR       (InLR),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutData    (OutData),
        .Flush      (Flush),
        .Level      (Level),
        .LeftCount  (LeftCount),
        .RightCount (RightCount)
    );

    typedef struct {
        logic [7:0] d;
        logic [2:0] n;
        logic       lr;
    } cmd_t;

    cmd_t       mq[$];
    bit         m_ov = 1'b0;
    logic [7:0] m_od = 8'h00;
    bit         m_lr = 1'b0;
    int         m_lc = 0;
    int         m_rc = 0;
    bit         mp_pop, mp_acc;
    cmd_t       mp_c;

    function automatic logic [7:0] rot_ref(input logic [7:0] x, input int k, input bit left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = left ? x[(i - k + 8) % 8] : x[(i + k) % 8];
        return r;
    endfunction

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction step per rising edge.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mq.delete();
            m_ov = 1'b0;
            m_od = 8'h00;
            m_lr = 1'b0;
            m_lc = 0;
            m_rc = 0;
        end else begin
            mp_pop = (mq.size() > 0) && (!m_ov || OutReady);
            mp_acc = InValid && ((mq.size() < DEPTH) || mp_pop);
            if (m_ov && OutReady) begin
                if (m_lr) m_lc = sat16(m_lc);
                else      m_rc = sat16(m_rc);
            end
            if (Flush) begin
                mq.delete();
                m_ov = 1'b0;
            end else begin
                if (mp_pop) begin
                    mp_c = mq.pop_front();
                    m_od = rot_ref(mp_c.d, int'(mp_c.n), mp_c.lr);
                    m_lr = mp_c.lr;
                    m_ov = 1'b1;
                end else if (OutReady) begin
                    m_ov = 1'b0;
                end
                if (mp_acc) mq.push_back('{d: InData, n: InNum, lr: InLR});
            end
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge Clk) begin
        #2;
        if (Rst_n) begin
            chk("m_outvalid", int'(OutValid), int'(m_ov));
            chk("m_outdata", int'(OutData), int'(m_od));
            chk("m_level", int'(Level), mq.size());
            chk("m_inready", int'(InReady),
                int'((mq.size() < DEPTH) || ((mq.size() > 0) && (!m_ov || OutReady))));
`ifdef BSEQ_STATS_EN
            chk("m_leftcount", int'(LeftCount), m_lc);
            chk("m_rightcount", int'(RightCount), m_rc);
`else
            chk("m_leftcount", int'(LeftCount), 0);
            chk("m_rightcount", int'(RightCount), 0);
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        #3;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] n, input logic lr);
        int waited;
        waited = 0;
        @(negedge Clk);
        InData = d;
        InNum = n;
        InLR = lr;
        InValid = 1'b1;
        forever begin
            #1;
            if (InReady) begin
                @(posedge Clk);
                #1;
                InValid = 1'b0;
                return;
            end
            waited++;
            if (waited > 30) begin
                checks++;
                failures++;
                $display("FAIL push_timeout: InReady stayed %0d expected 1", InReady);
                InValid = 1'b0;
                return;
            end
            @(negedge Clk);
        end
    endtask

    logic [7:0] exp35 [4] = '{8'h04, 8'hC0, 8'h40, 8'hFF};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int thr;
        // Reset state while Rst_n is held low
        #3;
        chk("rst_outvalid", int'(OutValid), 0);
        chk("rst_level", int'(Level), 0);
        chk("rst_inready", int'(InReady), 1);
        chk("rst_outdata", int'(OutData), 8'h00);
        chk("rst_leftcount", int'(LeftCount), 0);
        chk("rst_rightcount", int'(RightCount), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        OutReady = 1'b1;

        // Single command latency
        push(8'hB1, 3'd3, 1'b0);
        #2;
        chk("lat_ov_after_accept", int'(OutValid), 0);
        chk("lat_level_after_accept", int'(Level), 1);
        tick();
        chk("lat_ov_next", int'(OutValid), 1);
        chk("lat_data_b1", int'(OutData), 8'h36);
        tick();
        chk("lat_ov_drop", int'(OutValid), 0);
        chk("lat_data_hold", int'(OutData), 8'h36);

        // Back-to-back stream
        push(8'h81, 3'd1, 1'b1);
        push(8'hF0, 3'd4, 1'b1);
        #2;
        chk("b2b_first", int'(OutData), 8'h03);
        push(8'h5A, 3'd0, 1'b0);
        #2;
        chk("b2b_second", int'(OutData), 8'h0F);
        tick();
        chk("b2b_third", int'(OutData), 8'h5A);
        repeat (2) tick();

        // Backpressure: DEPTH+1 commands buffered
        @(negedge Clk);
        OutReady = 1'b0;
        push(8'h01, 3'd1, 1'b1);
        push(8'h02, 3'd1, 1'b1);
        push(8'h03, 3'd2, 1'b0);
        push(8'h80, 3'd7, 1'b1);
        push(8'hFF, 3'd5, 1'b0);
        #2;
        chk("bp_level_full", int'(Level), 4);
        chk("bp_inready_low", int'(InReady), 0);
        chk("bp_outdata", int'(OutData), 8'h02);
        tick();
        chk("bp_outdata_stable", int'(OutData), 8'h02);
        @(negedge Clk);
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_drain", int'(OutData), int'(exp35[i]));
        end
        tick();
        chk("bp_drained_ov", int'(OutValid), 0);
        chk("bp_drained_level", int'(Level), 0);

        // Push and pop together at full level
        @(negedge Clk);
        OutReady = 1'b0;
        push(8'h11, 3'd1, 1'b0);
        push(8'h22, 3'd2, 1'b1);
        push(8'h33, 3'd3, 1'b0);
        push(8'h44, 3'd4, 1'b1);
        push(8'h55, 3'd5, 1'b0);
        @(negedge Clk);
        OutReady = 1'b1;
        InData = 8'h3C;
        InNum = 3'd2;
        InLR = 1'b1;
        InValid = 1'b1;
        #1;
        chk("full_pushpop_inready", int'(InReady), 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        #2;
        chk("full_pushpop_level", int'(Level), 4);
        repeat (7) tick();
        chk("full_drain_level", int'(Level), 0);

        // Flush with commands pending
        @(negedge Clk);
        OutReady = 1'b0;
        push(8'h81, 3'd1, 1'b1);
        push(8'h12, 3'd1, 1'b0);
        push(8'h34, 3'd2, 1'b0);
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        #2;
        chk("flush_level", int'(Level), 0);
        chk("flush_ov", int'(OutValid), 0);
        chk("flush_data_hold", int'(OutData), 8'h03);

        // Asynchronous reset mid-burst
        @(negedge Clk);
        OutReady = 1'b0;
        push(8'hA5, 3'd1, 1'b0);
        push(8'hA6, 3'd2, 1'b1);
        push(8'hA7, 3'd3, 1'b0);
        push(8'hA8, 3'd4, 1'b1);
        #2;
        chk("midrst_level_before", int'(Level), 3);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("midrst_ov", int'(OutValid), 0);
        chk("midrst_level", int'(Level), 0);
        chk("midrst_inready", int'(InReady), 1);
        chk("midrst_data", int'(OutData), 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;
        OutReady = 1'b1;
        push(8'h01, 3'd7, 1'b0);
        tick();
        chk("postrst_data", int'(OutData), 8'h02);
        chk("postrst_ov", int'(OutValid), 1);

        // Statistics: 3 left and 2 right completions since reset
        push(8'h10, 3'd1, 1'b1);
        push(8'h20, 3'd2, 1'b1);
        push(8'h33, 3'd3, 1'b1);
        push(8'h44, 3'd4, 1'b0);
        repeat (4) tick();
`ifdef BSEQ_STATS_EN
        chk("stats_left", int'(LeftCount), 3);
        chk("stats_right", int'(RightCount), 2);
`else
        chk("stats_left", int'(LeftCount), 0);
        chk("stats_right", int'(RightCount), 0);
`endif
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        #2;
`ifdef BSEQ_STATS_EN
        chk("stats_left_flush", int'(LeftCount), 3);
        chk("stats_right_flush", int'(RightCount), 2);
`else
        chk("stats_left_flush", int'(LeftCount), 0);
        chk("stats_right_flush", int'(RightCount), 0);
`endif

        // Randomized traffic with varying backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            thr = (i / 300) % 4;
            InValid = 1'($urandom_range(0, 1));
            InData = 8'($urandom);
            InNum = 3'($urandom);
            InLR = 1'($urandom);
            OutReady = ($urandom_range(0, 3) >= thr);
            Flush = ($urandom_range(0, 59) == 0);
        end
        @(negedge Clk);
        InValid = 1'b0;
        Flush = 1'b0;
        OutReady = 1'b1;
        repeat (8) tick();
        chk("final_level", int'(Level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
